// File: rtl/sprite_dma_gen2.sv
// sprite_dma_gen2: parametrised APU sprite DMA engine.
// Copies LEN bytes from CPU page {page, cnt} to a fixed PPU port.
// Halts the core, aligns to the ACLK get/put phase and gives get slots to DMC fetches.
module sprite_dma_gen2 #(
  parameter int              ADDR_W    = 16,
  parameter int              DATA_W    = 8,
  parameter int              CNT_W     = 8,
  parameter int              LEN       = 256,
  parameter logic [ADDR_W-1:0] DEST_ADDR = 16'h2004
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              ACLK1,
  input  logic              RnW,
  input  logic              W4014,
  input  logic [DATA_W-1:0] DB_in,
  input  logic [ADDR_W-1:0] CPU_Addr,
  input  logic              DMC_REQ,
  input  logic [ADDR_W-1:0] DMC_Addr,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] DB_out,
  output logic              RD,
  output logic              WR,
  output logic              SPR_PPU,
  output logic              RDY_tocore,
  output logic              DMC_ACK,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_GET, S_PUT} state_t;

  // index of the final byte; the counter stops here and never wraps
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] page;
  logic [DATA_W-1:0] buf_q;
  logic              done_q;

  // state register
  always_ff @(posedge CLK) begin
    if (RES) state <= S_IDLE;
    else     state <= state_nx;
  end

  // datapath: page latch, byte counter, read buffer, one-shot done flag
  always_ff @(posedge CLK) begin
    if (RES) begin
      cnt    <= '0;
      page   <= '0;
      buf_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_PUT) && (cnt == LAST);
      // a strobe outside IDLE must not relatch the page or restart the count
      if (state == S_IDLE && W4014) begin
        page <= DB_in;
        cnt  <= '0;
      end
      if (state == S_GET && !DMC_REQ) buf_q <= DB_in;
      if (state == S_PUT && cnt != LAST) cnt <= cnt + CNT_W'(1);
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (W4014) state_nx = S_HALT;
      // wait for the core to be in a read cycle, then align to a get phase
      S_HALT:  if (RnW) state_nx = ACLK1 ? S_GET : S_ALIGN;
      S_ALIGN: state_nx = S_GET;
      // a DMC steal burns the get slot plus one realign cycle
      S_GET:   state_nx = DMC_REQ ? S_ALIGN : S_PUT;
      S_PUT:   state_nx = (cnt == LAST) ? S_IDLE : S_GET;
      default: state_nx = S_IDLE;
    endcase
  end

  // output decode from registered state, plus DMC_REQ in IDLE/GET
  always_comb begin
    Addr       = CPU_Addr;
    DB_out     = '0;
    RD         = 1'b0;
    WR         = 1'b0;
    SPR_PPU    = 1'b0;
    RDY_tocore = 1'b1;
    DMC_ACK    = 1'b0;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    case (state)
      S_IDLE: begin
        DONE = done_q;
        if (DMC_REQ) begin
          Addr       = DMC_Addr;
          RD         = 1'b1;
          DMC_ACK    = 1'b1;
          RDY_tocore = 1'b0;
        end
      end
      S_HALT, S_ALIGN: begin
        RDY_tocore = 1'b0;
        BUSY       = 1'b1;
      end
      S_GET: begin
        RDY_tocore = 1'b0;
        BUSY       = 1'b1;
        RD         = 1'b1;
        if (DMC_REQ) begin
          Addr    = DMC_Addr;
          DMC_ACK = 1'b1;
        end else begin
          Addr = ADDR_W'({page, cnt});
        end
      end
      S_PUT: begin
        RDY_tocore = 1'b0;
        BUSY       = 1'b1;
        Addr       = DEST_ADDR;
        WR         = 1'b1;
        SPR_PPU    = 1'b1;
        DB_out     = buf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sprite_dma_gen2.sv
// Bench for sprite_dma_gen2: each transfer is expanded into an expected
// per-cycle bus timeline from the transfer rules, then driven and compared.
module tb_sprite_dma_gen2;
  localparam int LEN = 256;

  logic        CLK = 1'b0;
  logic        RES, ACLK1, RnW, W4014, DMC_REQ;
  logic [7:0]  DB_in;
  logic [15:0] CPU_Addr, DMC_Addr;

  logic [15:0] Addr, Addr4;
  logic [7:0]  DB_out, DB_out4;
  logic        RD, WR, SPR_PPU, RDY_tocore, DMC_ACK, BUSY, DONE;
  logic        RD4, WR4, SPR_PPU4, RDY4, ACK4, BUSY4, DONE4;

  int checks = 0;
  int errors = 0;

  sprite_dma_gen2 dut (
    .CLK(CLK), .RES(RES), .ACLK1(ACLK1), .RnW(RnW), .W4014(W4014), .DB_in(DB_in),
    .CPU_Addr(CPU_Addr), .DMC_REQ(DMC_REQ), .DMC_Addr(DMC_Addr),
    .Addr(Addr), .DB_out(DB_out), .RD(RD), .WR(WR), .SPR_PPU(SPR_PPU),
    .RDY_tocore(RDY_tocore), .DMC_ACK(DMC_ACK), .BUSY(BUSY), .DONE(DONE));

  sprite_dma_gen2 #(.LEN(4)) dut4 (
    .CLK(CLK), .RES(RES), .ACLK1(ACLK1), .RnW(RnW), .W4014(W4014), .DB_in(DB_in),
    .CPU_Addr(CPU_Addr), .DMC_REQ(DMC_REQ), .DMC_Addr(DMC_Addr),
    .Addr(Addr4), .DB_out(DB_out4), .RD(RD4), .WR(WR4), .SPR_PPU(SPR_PPU4),
    .RDY_tocore(RDY4), .DMC_ACK(ACK4), .BUSY(BUSY4), .DONE(DONE4));

  always #5 CLK = ~CLK;

  typedef struct {
    bit          w, rd, wr, ack, dmc, rdy, busy, done, rst;
    logic [15:0] addr;
    logic [7:0]  d;
  } ent_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer. hold = core-write cycles in HALT, unal = exit HALT on a put phase,
  // steal_k / rst_k = byte index of a DMC steal / reset (-1 none),
  // ign = second strobe mid-transfer, alt = AA/55 data, chk4 = also check LEN=4 instance.
  task automatic xfer(input logic [7:0] pg, input int hold, input bit unal, input int steal_k,
                      input int rst_k, input bit ign, input bit alt, input bit chk4);
    ent_t       tl[$];
    ent_t       e;
    logic [7:0] d[LEN];
    logic [7:0] q4[$];
    int         exit_c, lowcnt, donecnt, done4;
    lowcnt = 0; donecnt = 0; done4 = 0;
    DMC_Addr = 16'($urandom);
    for (int k = 0; k < LEN; k++) d[k] = alt ? ((k % 2) ? 8'h55 : 8'hAA) : 8'($urandom);

    // expected timeline
    e = '{default: '0}; e.w = 1; e.rdy = 1; e.d = pg; tl.push_back(e);
    e = '{default: '0}; e.busy = 1;
    for (int i = 0; i <= hold; i++) tl.push_back(e);
    exit_c = hold + 1;
    if (unal) tl.push_back(e);
    for (int k = 0; k < LEN; k++) begin
      if (k == steal_k) begin
        e = '{default: '0}; e.busy = 1; e.rd = 1; e.ack = 1; e.dmc = 1; e.addr = DMC_Addr;
        tl.push_back(e);
        e = '{default: '0}; e.busy = 1; tl.push_back(e);
      end
      e = '{default: '0}; e.busy = 1; e.rd = 1; e.addr = {pg, 8'(k)}; e.d = d[k];
      e.rst = (k == rst_k);
      tl.push_back(e);
      if (k == rst_k) break;
      e = '{default: '0}; e.busy = 1; e.wr = 1; e.addr = 16'h2004; e.d = d[k];
      e.w = ign && (k == 5);
      tl.push_back(e);
    end
    if (rst_k < 0) begin
      e = '{default: '0}; e.rdy = 1; e.done = 1; tl.push_back(e);
    end
    e = '{default: '0}; e.rdy = 1;
    for (int i = 0; i < 4; i++) tl.push_back(e);

    // drive and compare cycle by cycle
    for (int c = 0; c < tl.size(); c++) begin
      e        = tl[c];
      W4014    = e.w;
      DB_in    = e.w ? ((c == 0) ? pg : ~pg) : e.d;
      RnW      = !(c >= 1 && c <= hold);
      ACLK1    = ((exit_c - c) & 1) ? unal : !unal;
      DMC_REQ  = e.dmc;
      RES      = e.rst;
      CPU_Addr = 16'($urandom);
      @(negedge CLK);
      chk("addr",    Addr,       (e.rd || e.wr) ? e.addr : CPU_Addr);
      chk("rd",      RD,         e.rd);
      chk("wr",      WR,         e.wr);
      chk("spr_ppu", SPR_PPU,    e.wr);
      chk("db_out",  DB_out,     e.wr ? e.d : 8'h00);
      chk("dmc_ack", DMC_ACK,    e.ack);
      chk("rdy",     RDY_tocore, e.rdy);
      chk("busy",    BUSY,       e.busy);
      chk("done",    DONE,       e.done);
      lowcnt  += RDY_tocore ? 0 : 1;
      donecnt += DONE ? 1 : 0;
      if (chk4 && WR4) q4.push_back(DB_out4);
      done4 += DONE4 ? 1 : 0;
      @(posedge CLK); #1;
    end
    RES = 0; W4014 = 0; DMC_REQ = 0;

    if (rst_k < 0) begin
      chk("rdy_low_cycles", lowcnt, hold + 1 + int'(unal) + 2 * LEN + ((steal_k >= 0) ? 2 : 0));
      chk("done_pulses", donecnt, 1);
    end else begin
      chk("done_after_reset", donecnt, 0);
    end
    if (chk4) begin
      chk("len4_puts", q4.size(), 4);
      for (int i = 0; i < q4.size() && i < 4; i++)
        chk("len4_data", q4[i], (i % 2) ? 8'h55 : 8'hAA);
      chk("len4_done", done4, 1);
    end
  endtask

  initial begin
    RES = 1; ACLK1 = 0; RnW = 1; W4014 = 0; DMC_REQ = 0;
    DB_in = 0; CPU_Addr = 16'h1234; DMC_Addr = 16'hC000;

    // reset state
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("rst_rdy", RDY_tocore, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_rd", RD, 1'b0);
    chk("rst_wr", WR, 1'b0);
    chk("rst_ack", DMC_ACK, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_addr", Addr, 16'h1234);
    chk("rst_dbout", DB_out, 8'h00);
    @(posedge CLK); #1;
    RES = 0;

    // DMC fetch while idle uses the bus directly
    DMC_REQ = 1; DMC_Addr = 16'hC123;
    @(negedge CLK);
    chk("idle_dmc_addr", Addr, 16'hC123);
    chk("idle_dmc_ack", DMC_ACK, 1'b1);
    chk("idle_dmc_rd", RD, 1'b1);
    chk("idle_dmc_rdy", RDY_tocore, 1'b0);
    chk("idle_dmc_busy", BUSY, 1'b0);
    @(posedge CLK); #1;
    DMC_REQ = 0;
    @(posedge CLK); #1;

    xfer(8'h02, 0, 0, -1, -1, 0, 1, 1);          // aligned, AA/55, LEN=4 instance
    xfer(8'h02, 0, 1, -1, -1, 0, 0, 0);          // unaligned
    xfer(8'($urandom), 3, 0, -1, -1, 0, 0, 0);   // core writing 3 cycles
    xfer(8'h02, 0, 0, 16, -1, 0, 0, 0);          // DMC steal at byte 0x10
    xfer(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, LEN - 1)),
         -1, 1, 0, 0);                            // random steal + ignored second strobe
    xfer(8'h07, 0, 0, -1, 128, 0, 0, 0);         // reset at byte 0x80
    xfer(8'($urandom), 2, 1, -1, -1, 1, 0, 0);   // normal transfer after abort

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
